// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
//           with bounded bursts, full/almostfull gating and write-ack checking.
// Latency : accept (o_gnt, combinational) -> o_fifo_wr_en/o_fifo_data_in one cycle later.
// Backpressure: no grant while the FIFO is full, or almostfull with a write in flight.
//
// Ports:
//   i_clk, i_rst          clock (posedge) and async active-high reset
//   i_req, i_req_data     per-requester request and data (slice i = [i*DATA_WIDTH +: DATA_WIDTH])
//   o_gnt                 one-hot accept; the word is taken at this posedge
//   o_fifo_wr_en/_data_in registered FIFO write
//   i_fifo_full/_almostfull/_wr_ack/_overflow  FIFO status
//   o_owner_id            current/last owner
//   o_ack_err, o_err_cnt  missing-ack pulse and saturating count
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4,
  localparam int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_data_in,
  input  logic                          i_fifo_full,
  input  logic                          i_fifo_almostfull,
  input  logic                          i_fifo_wr_ack,
  input  logic                          i_fifo_overflow,
  output logic [IW-1:0]                 o_owner_id,
  output logic                          o_ack_err,
  output logic [7:0]                    o_err_cnt
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_STALL} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_owner;
  logic [IW-1:0]         r_rr;
  logic [BW-1:0]         r_burst;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_pending;
  logic                  r_ack_err;
  logic [7:0]            r_err_cnt;

  logic                  w_blocked;
  logic                  w_owner_req;
  logic                  w_burst_max;
  logic                  w_continue;
  logic                  w_rotate;
  logic [IW-1:0]         w_owner_inc;
  logic [IW-1:0]         w_base;
  logic [IW-1:0]         w_idx;
  logic [IW-1:0]         w_pick;
  logic                  w_any;
  logic                  w_gnt_en;
  logic [IW-1:0]         w_gnt_idx;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_ack_bad;

  // An almostfull FIFO with a write already in flight has no slot for another.
  assign w_blocked   = i_fifo_full | (i_fifo_almostfull & r_wr_en);
  assign w_owner_req = i_req[r_owner];
  assign w_burst_max = (r_burst == BW'(MAX_BURST));
  assign w_continue  = w_owner_req & ~w_blocked & ~w_burst_max;
  // Owner gives up the port: burst used up or nothing more to send.
  assign w_rotate    = (r_state == S_BURST) & ~w_continue & (w_burst_max | ~w_owner_req);
  assign w_owner_inc = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  // On rotation the search starts after the old owner in the same cycle.
  assign w_base      = w_rotate ? w_owner_inc : r_rr;

  // First requester at or after w_base; scanning downward lets the nearest one win.
  always_comb begin
    w_any  = 1'b0;
    w_pick = w_base;
    w_idx  = w_base;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = IW'((int'(w_base) + k) % NUM_REQ);
      if (i_req[w_idx]) begin
        w_pick = w_idx;
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_gnt_en  = 1'b0;
    w_gnt_idx = r_owner;
    case (r_state)
      S_IDLE: begin
        if (w_any && !w_blocked) begin
          w_gnt_en  = 1'b1;
          w_gnt_idx = w_pick;
        end
      end
      S_BURST: begin
        if (w_continue) begin
          w_gnt_en = 1'b1;
        end else if (w_rotate && w_any && !w_blocked) begin
          w_gnt_en  = 1'b1;
          w_gnt_idx = w_pick;
        end
      end
      S_STALL: begin
        if (!w_blocked) begin
          if (w_owner_req) begin
            w_gnt_en = 1'b1;
          end else if (w_any) begin
            w_gnt_en  = 1'b1;
            w_gnt_idx = w_pick;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == IW'(i)) w_gnt_data = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Reset forces the grant low immediately even though requests may be up.
  assign o_gnt     = (w_gnt_en && !i_rst) ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign w_ack_bad = r_pending & (~i_fifo_wr_ack | i_fifo_overflow);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_owner   <= '0;
      r_rr      <= '0;
      r_burst   <= '0;
      r_wr_en   <= 1'b0;
      r_data    <= '0;
      r_pending <= 1'b0;
      r_ack_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_wr_en <= w_gnt_en;
      if (w_gnt_en) r_data <= w_gnt_data;

      r_pending <= r_wr_en;
      r_ack_err <= w_ack_bad;
      if (w_ack_bad && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;

      // IDLE, rotation and an abandoned stall all fall into the same re-arbitration.
      if ((r_state == S_IDLE) || w_rotate || (r_state == S_STALL && !w_blocked && !w_owner_req)) begin
        if (w_rotate) r_rr <= w_owner_inc;
        if (w_any) begin
          r_owner <= w_pick;
          if (!w_blocked) begin
            r_burst <= BW'(1);
            r_state <= S_BURST;
          end else begin
            r_burst <= '0;
            r_state <= S_STALL;
          end
        end else begin
          r_burst <= '0;
          r_state <= S_IDLE;
        end
      end else if (r_state == S_BURST) begin
        if (w_continue) r_burst <= r_burst + 1'b1;
        else            r_state <= S_STALL;
      end else if (r_state == S_STALL) begin
        // Stalled owner resumes with its burst count intact.
        if (!w_blocked) begin
          r_burst <= r_burst + 1'b1;
          r_state <= S_BURST;
        end
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign o_fifo_wr_en   = r_wr_en;
  assign o_fifo_data_in = r_data;
  assign o_owner_id     = r_owner;
  assign o_ack_err      = r_ack_err;
  assign o_err_cnt      = r_err_cnt;

endmodule
